// File: rtl/uart_msg_tx.sv
// uart_msg_tx: UART transmitter that serialises a fixed parameter-defined message per start pulse
module uart_msg_tx #(
    parameter int CLK_DIV = 434,
    parameter int DATA_BITS = 8,
    parameter int PARITY = 0,
    parameter int STOP_BITS = 1,
    parameter int MSG_LEN = 4,
    parameter logic [MSG_LEN*DATA_BITS-1:0] MSG = "abcd",
    parameter int GAP_BITS = 2,
    localparam int CW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          repeat_en,
    output logic          txd,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] char_idx
);
    localparam int BDW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS + STOP_BITS + GAP_BITS + 1);
    localparam logic [BDW-1:0] RELOAD = BDW'(CLK_DIV - 1);
    if (PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 || DATA_BITS < 5 ||
        DATA_BITS > 8 || CLK_DIV < 2 || MSG_LEN < 1 || GAP_BITS < 0) begin : g_bad_cfg
        $error("uart_msg_tx: unsupported parameter set");
    end
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, GAP} state_t;
    state_t state;
    logic [BDW-1:0] cnt;
    logic [BW-1:0] bitc;
    logic [DATA_BITS-1:0] chr, sh;
    logic bit_end, par;
    // character 0 lives in the most significant slice of MSG
    always_comb begin
        chr = DATA_BITS'(MSG >> (DATA_BITS * (MSG_LEN - 1 - int'(char_idx))));
        par = (PARITY == 1) ? ^chr : ~^chr;
        bit_end = (cnt == '0);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            txd <= 1'b1;
            busy <= 1'b0;
            done <= 1'b0;
            char_idx <= '0;
            cnt <= '0;
            bitc <= '0;
            sh <= '0;
        end else begin
            done <= 1'b0;
            cnt <= (state == IDLE || bit_end) ? RELOAD : cnt - 1'b1;
            case (state)
                IDLE: if (start && !done) begin
                    state <= START;
                    txd <= 1'b0;
                    busy <= 1'b1;
                    char_idx <= '0;
                end
                START: if (bit_end) begin
                    state <= DATA;
                    txd <= chr[0];
                    sh <= chr >> 1;
                    bitc <= '0;
                end
                DATA: if (bit_end) begin
                    if (bitc == BW'(DATA_BITS - 1)) begin
                        state <= (PARITY != 0) ? PAR : STOP;
                        txd <= (PARITY != 0) ? par : 1'b1;
                        bitc <= '0;
                    end else begin
                        txd <= sh[0];
                        sh <= sh >> 1;
                        bitc <= bitc + 1'b1;
                    end
                end
                PAR: if (bit_end) begin
                    state <= STOP;
                    txd <= 1'b1;
                end
                STOP: if (bit_end) begin
                    if (bitc != BW'(STOP_BITS - 1)) bitc <= bitc + 1'b1;
                    else if (int'(char_idx) < MSG_LEN - 1) begin
                        char_idx <= char_idx + 1'b1;
                        state <= START;
                        txd <= 1'b0;
                    end else begin
                        done <= 1'b1;
                        bitc <= '0;
                        if (!repeat_en) begin
                            state <= IDLE;
                            busy <= 1'b0;
                            char_idx <= '0;
                        end else if (GAP_BITS > 0) state <= GAP;
                        else begin
                            state <= START;
                            txd <= 1'b0;
                            char_idx <= '0;
                        end
                    end
                end
                GAP: if (bit_end) begin
                    if (bitc != BW'(GAP_BITS - 1)) bitc <= bitc + 1'b1;
                    else begin
                        state <= START;
                        txd <= 1'b0;
                        char_idx <= '0;
                        bitc <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
